adder_8bit: RTL and testbench

Registered 8-bit ripple-carry adder with an exposed per-stage carry vector. Adds two bytes plus a carry-in and presents the byte sum and all eight internal stage carries one clock later. Used as the arithmetic leaf of datapaths that need stage carries for overflow or flag generation.

---
 rtl/adder_8bit_pkg.sv | 10 +
 rtl/adder_8bit_full_adder_1bit.sv | 14 +
 rtl/adder_8bit.sv | 54 +++++
 tb/tb_adder_8bit.sv | 115 +++++++++++
 4 files changed

// File: rtl/adder_8bit_pkg.sv
// Shared constants and types for the registered 8-bit ripple-carry adder.
package adder_8bit_pkg;

    // Operand width of the adder datapath.
    localparam int unsigned WIDTH = 8;

    // Byte-wide vector used for operands, sums and stage carries.
    typedef logic [WIDTH-1:0] byte_vec_t;

endpackage : adder_8bit_pkg

// File: rtl/adder_8bit_full_adder_1bit.sv
// Single-bit full adder: one stage of the ripple-carry chain.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    // Sum and majority carry of the three inputs.
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule : full_adder_1bit

// File: rtl/adder_8bit.sv
// Registered ripple-carry adder exposing every stage carry one cycle after capture.
module adder_8bit
    import adder_8bit_pkg::*;
#(
    parameter int unsigned WIDTH = adder_8bit_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] first_byte,
    input  logic [WIDTH-1:0] second_byte,
    input  logic [WIDTH-1:0] carry_in,
    output logic [WIDTH-1:0] sum_bytes,
    output logic [WIDTH-1:0] carry_out
);

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic [WIDTH-1:0] chain;
    logic             unused_carry_in;

    // Only bit 0 of carry_in enters the chain; the upper bits are deliberately dropped.
    assign unused_carry_in = ^carry_in[WIDTH-1:1];

    // Carry into stage i: external carry for stage 0, previous stage carry otherwise.
    assign chain = {carry_d[WIDTH-2:0], carry_in[0]};

    // Ripple chain of full adders, one per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder_1bit u_fa (
            .a  (first_byte[i]),
            .b  (second_byte[i]),
            .c  (chain[i]),
            .s  (sum_d[i]),
            .co (carry_d[i])
        );
    end

    // Output register bank; reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum_bytes = sum_q;
    assign carry_out = carry_q;

endmodule : adder_8bit

// File: tb/tb_adder_8bit.sv
// Scoreboard bench for adder_8bit: driver queues expected results, monitor checks after each edge.
module tb_adder_8bit;
    import adder_8bit_pkg::*;

    typedef struct {
        byte_vec_t sum;
        byte_vec_t carry;
        string     name;
    } exp_t;

    logic      clk;
    logic      rst;
    byte_vec_t first_byte;
    byte_vec_t second_byte;
    byte_vec_t carry_in;
    byte_vec_t sum_bytes;
    byte_vec_t carry_out;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    adder_8bit dut (
        .clk         (clk),
        .rst         (rst),
        .first_byte  (first_byte),
        .second_byte (second_byte),
        .carry_in    (carry_in),
        .sum_bytes   (sum_bytes),
        .carry_out   (carry_out)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one operand set at the falling edge and queue the result expected after the next rising edge.
    task automatic drive(input logic r, input byte_vec_t a, input byte_vec_t b, input byte_vec_t cin,
                         input byte_vec_t exp_sum, input byte_vec_t exp_carry, input string name);
        exp_t e;
        @(negedge clk);
        rst         = r;
        first_byte  = a;
        second_byte = b;
        carry_in    = cin;
        e.sum       = exp_sum;
        e.carry     = exp_carry;
        e.name      = name;
        sb_q.push_back(e);
    endtask

    // Monitor: just after each rising edge, compare outputs with the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (sum_bytes !== e.sum) begin
                n_fail++;
                $display("FAIL %s sum_bytes: got %02h expected %02h", e.name, sum_bytes, e.sum);
            end
            n_checks++;
            if (carry_out !== e.carry) begin
                n_fail++;
                $display("FAIL %s carry_out: got %02h expected %02h", e.name, carry_out, e.carry);
            end
        end
    end

    // Directed stimulus with hand-computed results.
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        first_byte  = 8'hAA;
        second_byte = 8'h55;
        carry_in    = 8'hFF;

        drive(1'b1, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, "reset_0");
        drive(1'b1, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, "reset_1");
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "zero_add");
        drive(1'b0, 8'h02, 8'h02, 8'h00, 8'h04, 8'h02, "stage1_carry");
        drive(1'b0, 8'h60, 8'h02, 8'h00, 8'h62, 8'h00, "no_carry");
        drive(1'b0, 8'hFF, 8'h01, 8'h00, 8'h00, 8'hFF, "full_ripple_wrap");
        drive(1'b0, 8'hFF, 8'h00, 8'h01, 8'h00, 8'hFF, "cin_ripple");
        drive(1'b0, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, "cin_upper_ignored");
        drive(1'b0, 8'h10, 8'h20, 8'hFE, 8'h30, 8'h00, "cin_upper_ignored2");
        drive(1'b0, 8'h7F, 8'h01, 8'hFE, 8'h80, 8'h7F, "ripple_to_msb");
        drive(1'b0, 8'h80, 8'h80, 8'h00, 8'h00, 8'h80, "msb_only_carry");
        drive(1'b0, 8'hA5, 8'h5A, 8'h01, 8'h00, 8'hFF, "alt_bits_cin");
        drive(1'b0, 8'h0F, 8'h01, 8'h00, 8'h10, 8'h0F, "low_nibble_ripple");
        drive(1'b0, 8'h12, 8'h34, 8'h01, 8'h47, 8'h30, "mixed");
        drive(1'b0, 8'hFF, 8'h00, 8'h01, 8'h00, 8'hFF, "b2b_first");
        drive(1'b1, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, "b2b_second_reset");
        drive(1'b0, 8'h12, 8'h34, 8'h01, 8'h47, 8'h30, "first_after_reset");
        drive(1'b0, 8'hC8, 8'h64, 8'h00, 8'h2C, 8'hC0, "wrap_partial");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adder_8bit
